// File: rtl/alu_if.sv
// Operand/result bundle between the WISC datapath and the alu.
interface alu_if;
   logic [15:0] data_one;
   logic [15:0] data_two;
   logic [3:0]  shift;
   logic [2:0]  control;
   logic [15:0] result;
   logic [2:0]  flags;
   logic        done;

   modport master (
      output data_one, data_two, shift, control,
      input  result, flags, done
   );

   modport slave (
      input  data_one, data_two, shift, control,
      output result, flags, done
   );
endinterface

// File: rtl/alu.sv
// 16-bit WISC ALU: combinational result, registered Z/V/N flags, input-stable done.
// Optional macro ALU_SAT_EN: saturate ADD/SUB/INC on signed overflow.
module alu #(
   parameter int unsigned WIDTH = 16
) (
   input logic   clk,
   input logic   rst_n,
   alu_if.slave  bus
);
   localparam int unsigned MSB    = WIDTH - 1;
   localparam int unsigned SAMP_W = 3 + 2 * WIDTH + 4;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;
   localparam logic [2:0] OP_SRA  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_SLL  = 3'b111;

   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [WIDTH-1:0]  arith;
   logic [WIDTH-1:0]  res;
   logic              ovf;
   logic              is_arith;
   logic              set_flags;
   logic [2:0]        flags_d;
   logic [2:0]        flags_q;
   logic [SAMP_W-1:0] samp_d;
   logic [SAMP_W-1:0] samp_q;
   logic              valid_q;

   assign a = WIDTH'(bus.data_one);
   assign b = WIDTH'(bus.data_two);

   // Result datapath; overflow direction always follows A's sign for add and subtract.
   always_comb begin
      arith     = '0;
      ovf       = 1'b0;
      res       = '0;
      is_arith  = 1'b0;
      set_flags = 1'b0;
      case (bus.control)
         OP_ADD, OP_INC: begin
            arith     = a + b;
            ovf       = (a[MSB] == b[MSB]) && (arith[MSB] != a[MSB]);
            is_arith  = 1'b1;
            set_flags = 1'b1;
         end
         OP_SUB: begin
            arith     = a - b;
            ovf       = (a[MSB] != b[MSB]) && (arith[MSB] != a[MSB]);
            is_arith  = 1'b1;
            set_flags = 1'b1;
         end
         OP_NAND: begin
            res       = ~(a & b);
            set_flags = 1'b1;
         end
         OP_XOR: begin
            res       = a ^ b;
            set_flags = 1'b1;
         end
         OP_SRA:  res = WIDTH'($signed(a) >>> bus.shift);
         OP_SRL:  res = a >> bus.shift;
         OP_SLL:  res = a << bus.shift;
         default: res = '0;
      endcase
      if (is_arith) begin
`ifdef ALU_SAT_EN
         if (ovf) res = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         else     res = arith;
`else
         res = arith;
`endif
      end
   end

   assign flags_d = {(res == '0), (is_arith & ovf), (is_arith & res[MSB])};
   assign samp_d  = {bus.control, bus.data_one, bus.data_two, bus.shift};

   // Flag register holds across shift opcodes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
         samp_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (set_flags) flags_q <= flags_d;
         samp_q  <= samp_d;
         valid_q <= 1'b1;
      end
   end

   assign bus.result = 16'(res);
   assign bus.flags  = flags_q;
   assign bus.done   = valid_q & (samp_q == samp_d);
endmodule

// File: tb/tb_alu.sv
// Directed vector bench for the alu: table vectors, arithmetic sweeps, shift walk, reset/done.
module tb_alu;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;
   localparam logic [2:0] OP_SRA  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_SLL  = 3'b111;
   localparam int NVEC = 16;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  sh;
      logic [15:0] res;
      logic [2:0]  fl;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t tbl [NVEC];

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh);
      @(negedge clk);
      bus.control  = op;
      bus.data_one = a;
      bus.data_two = b;
      bus.shift    = sh;
      #1;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      logic [15:0] er;
      logic [15:0] ex;
      logic [2:0]  ef;
      logic [2:0]  ops [3];

      checks = 0;
      errors = 0;
      tbl[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 4'd0,  16'h8000, 3'b011};
      tbl[1]  = '{OP_SUB,  16'h8000, 16'h0001, 4'd0,  16'h7FFF, 3'b010};
      tbl[2]  = '{OP_SUB,  16'h1234, 16'h1234, 4'd0,  16'h0000, 3'b100};
      tbl[3]  = '{OP_NAND, 16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 3'b100};
      tbl[4]  = '{OP_XOR,  16'hA5A5, 16'h5A5A, 4'd0,  16'hFFFF, 3'b000};
      tbl[5]  = '{OP_INC,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b100};
      tbl[6]  = '{OP_SRA,  16'h8001, 16'h0000, 4'd4,  16'hF800, 3'b100};
      tbl[7]  = '{OP_SRL,  16'h8001, 16'h0000, 4'd4,  16'h0800, 3'b100};
      tbl[8]  = '{OP_SLL,  16'h8001, 16'h0000, 4'd15, 16'h8000, 3'b100};
      tbl[9]  = '{OP_SLL,  16'h8001, 16'h0000, 4'd0,  16'h8001, 3'b100};
      tbl[10] = '{OP_ADD,  16'h8000, 16'h8000, 4'd0,  16'h0000, 3'b110};
      tbl[11] = '{OP_SRA,  16'h8001, 16'h1111, 4'd15, 16'hFFFF, 3'b110};
      tbl[12] = '{OP_SRL,  16'h8001, 16'h0000, 4'd15, 16'h0001, 3'b110};
      tbl[13] = '{OP_ADD,  16'h0001, 16'hFFFF, 4'd0,  16'h0000, 3'b100};
      tbl[14] = '{OP_SUB,  16'h0000, 16'h8000, 4'd0,  16'h8000, 3'b011};
      tbl[15] = '{OP_XOR,  16'h1234, 16'h1234, 4'd0,  16'h0000, 3'b100};

      // Reset state
      rst_n        = 1'b0;
      bus.control  = 3'b000;
      bus.data_one = 16'h0000;
      bus.data_two = 16'h0000;
      bus.shift    = 4'd0;
      #3;
      chk("reset_flags", 32'(bus.flags), 32'(3'b000));
      chk("reset_done", 32'(bus.done), 32'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors
      for (int i = 0; i < NVEC; i++) begin
         apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh);
         chk($sformatf("vec%0d_result", i), 32'(bus.result), 32'(tbl[i].res));
         edge_wait();
         chk($sformatf("vec%0d_flags", i), 32'(bus.flags), 32'(tbl[i].fl));
         chk($sformatf("vec%0d_result_post", i), 32'(bus.result), 32'(tbl[i].res));
      end

      // Shift walk of 0x8001; flags set to 001 beforehand must hold
      apply(OP_SUB, 16'h0000, 16'h0001, 4'd0);
      chk("pre_shift_result", 32'(bus.result), 32'(16'hFFFF));
      edge_wait();
      chk("pre_shift_flags", 32'(bus.flags), 32'(3'b001));
      for (int sh = 0; sh < 16; sh++) begin
         for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
               apply(OP_SRA, 16'h8001, 16'h0000, 4'(sh));
               ex = (16'h8001 >> sh) | ~(16'hFFFF >> sh);
            end else if (k == 1) begin
               apply(OP_SRL, 16'h8001, 16'h0000, 4'(sh));
               ex = 16'h8001 >> sh;
            end else begin
               apply(OP_SLL, 16'h8001, 16'h0000, 4'(sh));
               ex = 16'h8001 << sh;
            end
            chk($sformatf("shift_k%0d_s%0d", k, sh), 32'(bus.result), 32'(ex));
            edge_wait();
            chk($sformatf("shift_hold_k%0d_s%0d", k, sh), 32'(bus.flags), 32'(3'b001));
         end
      end

      // Arithmetic sweeps against an integer model
      ops[0] = OP_ADD;
      ops[1] = OP_SUB;
      ops[2] = OP_INC;
      for (int o = 0; o < 3; o++) begin
         for (int ai = -32768; ai <= 32694; ai += 73 * 32) begin
            for (int bi = -32768; bi <= 32694; bi += 73 * 32) begin
               s  = (ops[o] == OP_SUB) ? (ai - bi) : (ai + bi);
               er = 16'(s);
               ef = {(er == 16'h0000), ((s > 32767) || (s < -32768)), er[15]};
               apply(ops[o], 16'(ai), 16'(bi), 4'd0);
               chk($sformatf("sweep_op%0d_%0d_%0d_res", o, ai, bi), 32'(bus.result), 32'(er));
               edge_wait();
               chk($sformatf("sweep_op%0d_%0d_%0d_flags", o, ai, bi), 32'(bus.flags), 32'(ef));
            end
         end
      end

      // done tracks input stability
      apply(OP_ADD, 16'h7FFF, 16'h0001, 4'd0);
      edge_wait();
      chk("done_stable", 32'(bus.done), 32'(1'b1));
      @(negedge clk);
      bus.shift = 4'd3;
      #1;
      chk("done_drop", 32'(bus.done), 32'(1'b0));
      edge_wait();
      chk("done_return", 32'(bus.done), 32'(1'b1));
      chk("flags_before_reset", 32'(bus.flags), 32'(3'b011));

      // Mid-cycle reset
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_flags", 32'(bus.flags), 32'(3'b000));
      chk("midrst_done", 32'(bus.done), 32'(1'b0));
      chk("midrst_result", 32'(bus.result), 32'(16'h8000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst_done_low", 32'(bus.done), 32'(1'b0));
      edge_wait();
      chk("postrst_flags", 32'(bus.flags), 32'(3'b011));
      chk("postrst_done", 32'(bus.done), 32'(1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
